// File: rtl/mem_port_arbiter.sv
// Three-requester memory port arbiter: data > fetch > debug with debug aging.
// One access in flight at a time; a timeout aborts accesses that never complete.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 15,
    parameter int AGE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [2:0] AGE_MAX   = 3'(AGE_LIMIT);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        age_cnt;
    logic [3:0]        wait_cnt;
    logic [2:0]        win_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        pick;
    logic              age_win;
    logic              any_req;

    assign any_req = d_req | f_req | g_req;

    // Terms are made mutually exclusive so the one-hot decode stays unique.
    always_comb begin
        age_win = g_req && (age_cnt == AGE_MAX);
        pick    = 3'b000;
        unique case (1'b1)
            age_win:                                 pick = 3'b100;
            (!age_win && d_req):                     pick = 3'b001;
            (!age_win && !d_req && f_req):           pick = 3'b010;
            (!age_win && !d_req && !f_req && g_req): pick = 3'b100;
            default:                                 pick = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = any_req ? BUSY : IDLE;
            BUSY: begin
                if (mem_ready || wait_cnt == WAIT_LAST) state_nxt = DONE;
                else                                    state_nxt = BUSY;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        gnt       = (state == BUSY || state == DONE) ? win_q : 3'b000;
        done      = (state == DONE) ? win_q : 3'b000;
        err       = (state == DONE) && err_q;
        mem_read  = (state == BUSY) && !we_q;
        mem_write = (state == BUSY) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_cnt  <= '0;
            wait_cnt <= '0;
            win_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (!g_req || pick[2])      age_cnt <= '0;
                    else if (age_cnt != AGE_MAX) age_cnt <= age_cnt + 3'd1;
                    if (any_req) begin
                        win_q <= pick;
                        err_q <= 1'b0;
                        unique case (1'b1)
                            pick[0]: begin
                                addr_q  <= d_addr;
                                we_q    <= d_we;
                                wdata_q <= d_wdata;
                            end
                            pick[1]: begin
                                addr_q  <= f_addr;
                                we_q    <= 1'b0;
                                wdata_q <= '0;
                            end
                            pick[2]: begin
                                addr_q  <= g_addr;
                                we_q    <= g_we;
                                wdata_q <= g_wdata;
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // A ready in the final wait cycle still counts as success.
                    if (mem_ready) begin
                        err_q <= 1'b0;
                        if (!we_q) rdata <= mem_rdata;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                        rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, aging,
// timeout, ready-at-timeout and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_req, d_we, f_req, g_req, g_we;
    logic [15:0] d_addr, d_wdata, f_addr, g_addr, g_wdata;
    logic [2:0]  gnt, done;
    logic        err, busy, mem_read, mem_write, mem_ready;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_req(f_req), .f_addr(f_addr),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        f_req = 0; f_addr = '0;
        g_req = 0; g_we = 0; g_addr = '0; g_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        step(); step();
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_gnt", 16'(gnt), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_maddr", mem_addr, 16'h0);
        check("rst_strb", 16'({mem_read, mem_write}), 16'h0);
        check("rst_age", 16'(dut.age_cnt), 16'h0);
        reset = 1'b0;
        step();

        // Single fetch, ready on first BUSY cycle
        f_req = 1; f_addr = 16'h0010; mem_ready = 1; mem_rdata = 16'hA5C3;
        step();
        check("f_busy", 16'(busy), 16'h1);
        check("f_gnt", 16'(gnt), 16'h2);
        check("f_read", 16'(mem_read), 16'h1);
        check("f_addr", mem_addr, 16'h0010);
        check("f_nodone", 16'(done), 16'h0);
        step();
        check("f_done", 16'(done), 16'h2);
        check("f_rdata", rdata, 16'hA5C3);
        check("f_err", 16'(err), 16'h0);
        check("f_read_off", 16'(mem_read), 16'h0);
        check("f_gnt_hold", 16'(gnt), 16'h2);
        f_req = 0;
        step();
        check("f_idle", 16'(busy), 16'h0);
        check("f_done_off", 16'(done), 16'h0);

        // Data and fetch together
        d_req = 1; d_we = 0; d_addr = 16'h0100;
        f_req = 1; f_addr = 16'h0200; mem_rdata = 16'h1111;
        step();
        check("df_gnt_d", 16'(gnt), 16'h1);
        check("df_addr_d", mem_addr, 16'h0100);
        step();
        check("df_done_d", 16'(done), 16'h1);
        check("df_rdata_d", rdata, 16'h1111);
        d_req = 0;
        step();
        check("df_idle", 16'(busy), 16'h0);
        mem_rdata = 16'h2222;
        step();
        check("df_gnt_f", 16'(gnt), 16'h2);
        check("df_addr_f", mem_addr, 16'h0200);
        step();
        check("df_done_f", 16'(done), 16'h2);
        check("df_rdata_f", rdata, 16'h2222);
        f_req = 0;
        step();

        // Debug aging: loses four times, wins the fifth
        g_req = 1; g_we = 1; g_addr = 16'h0300; g_wdata = 16'hBEEF;
        d_req = 1; d_we = 0; d_addr = 16'h0101;
        for (int k = 0; k < 4; k++) begin
            step();
            check("age_gnt_d", 16'(gnt), 16'h1);
            check("age_cnt", 16'(dut.age_cnt), 16'(k + 1));
            step();
            check("age_done_d", 16'(done), 16'h1);
            step();
        end
        step();
        check("age_gnt_g", 16'(gnt), 16'h4);
        check("age_clr", 16'(dut.age_cnt), 16'h0);
        check("age_write", 16'(mem_write), 16'h1);
        check("age_wdata", mem_wdata, 16'hBEEF);
        check("age_gaddr", mem_addr, 16'h0300);
        step();
        check("age_done_g", 16'(done), 16'h4);
        g_req = 0;
        step();
        step();
        check("age_after_d", 16'(gnt), 16'h1);
        check("age_after_cnt", 16'(dut.age_cnt), 16'h0);
        d_req = 0;
        step();
        step();

        // Store that never completes: timeout after 15 BUSY cycles
        d_req = 1; d_we = 1; d_addr = 16'h0400; d_wdata = 16'h5A5A;
        mem_ready = 0;
        step();
        for (int i = 0; i < 15; i++) begin
            check("to_write", 16'(mem_write), 16'h1);
            check("to_nodone", 16'(done), 16'h0);
            step();
        end
        check("to_done", 16'(done), 16'h1);
        check("to_err", 16'(err), 16'h1);
        check("to_rdata", rdata, 16'h0);
        check("to_write_off", 16'(mem_write), 16'h0);
        d_req = 0;
        step();
        check("to_err_off", 16'(err), 16'h0);

        // Ready arriving exactly at the timeout cycle is a success
        d_req = 1; d_we = 0; d_addr = 16'h0500; mem_rdata = 16'h7777;
        step();
        for (int i = 0; i < 14; i++) step();
        check("rt_still_busy", 16'(mem_read), 16'h1);
        mem_ready = 1;
        step();
        check("rt_done", 16'(done), 16'h1);
        check("rt_err", 16'(err), 16'h0);
        check("rt_rdata", rdata, 16'h7777);
        d_req = 0;
        step();

        // Reset in the 2nd BUSY cycle of a store
        d_req = 1; d_we = 1; d_addr = 16'h0600; d_wdata = 16'h1234;
        mem_ready = 0;
        step();
        step();
        check("rs_write_pre", 16'(mem_write), 16'h1);
        reset = 1;
        step();
        check("rs_write", 16'(mem_write), 16'h0);
        check("rs_busy", 16'(busy), 16'h0);
        check("rs_done", 16'(done), 16'h0);
        reset = 0; d_req = 0;
        step();
        check("rs_nodone", 16'(done), 16'h0);
        f_req = 1; f_addr = 16'h0700; mem_ready = 1; mem_rdata = 16'h4321;
        step();
        check("rs_gnt_f", 16'(gnt), 16'h2);
        step();
        check("rs_done_f", 16'(done), 16'h2);
        check("rs_rdata_f", rdata, 16'h4321);
        f_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
